// File: rtl/crc_frame_seq.sv
// Byte-stream front end for a bit-serial CRC engine: clears the engine per frame,
// serializes accepted bytes into it and holds the finished CRC on a result port.
module crc_frame_seq #(
   parameter int CRC_W    = 8,
   parameter bit DATA_REF = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             crc_rst,
   output logic             crc_bit,
   output logic             crc_en,
   input  logic [CRC_W-1:0] crc_val,
   output logic             out_valid,
   output logic [CRC_W-1:0] out_crc,
   input  logic             out_ready,
   output logic             busy,
   output logic [2:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are
   // both high; valid never waits on ready, and a presented result stays until taken.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_WAIT  = 3'd2,
      S_SHIFT = 3'd3,
      S_LATCH = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             last_q, last_d;
   logic [CRC_W-1:0] out_crc_q, out_crc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         last_q    <= 1'b0;
         out_crc_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         out_crc_q <= out_crc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      out_crc_d = out_crc_q;
      case (state_q)
         S_IDLE: begin
            // The first byte is only consumed after the engine has been cleared.
            if (in_valid) state_d = S_CLEAR;
         end
         S_CLEAR: state_d = S_WAIT;
         S_WAIT: begin
            if (in_valid) begin
               shreg_d = in_data;
               last_d  = in_last;
               cnt_d   = 3'd0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d = DATA_REF ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = last_q ? S_LATCH : S_WAIT;
         end
         S_LATCH: begin
            // Eight enabled edges have elapsed, so the engine output is final here.
            out_crc_d = crc_val;
            state_d   = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_WAIT);
   assign crc_rst   = (state_q == S_IDLE) || (state_q == S_CLEAR);
   assign crc_en    = (state_q == S_SHIFT);
   assign crc_bit   = (state_q == S_SHIFT) && (DATA_REF ? shreg_q[0] : shreg_q[7]);
   assign out_valid = (state_q == S_DONE);
   assign out_crc   = out_crc_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_crc_frame_seq.sv
// Directed bench for crc_frame_seq: two instances (MSb-first and LSb-first), each
// wired to a small bit-serial CRC-8 engine model.
module tb_crc_frame_seq;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid0, in_valid1, in_last, out_ready;
   logic [7:0] in_data;

   logic       in_ready0, crc_rst0, crc_bit0, crc_en0, out_valid0, busy0;
   logic       in_ready1, crc_rst1, crc_bit1, crc_en1, out_valid1, busy1;
   logic [7:0] crc_val0, crc_val1, out_crc0, out_crc1;
   logic [2:0] dbg_state0, dbg_state1;

   crc_frame_seq #(.CRC_W(8), .DATA_REF(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready0), .crc_rst(crc_rst0), .crc_bit(crc_bit0), .crc_en(crc_en0),
      .crc_val(crc_val0), .out_valid(out_valid0), .out_crc(out_crc0), .out_ready(out_ready),
      .busy(busy0), .dbg_state(dbg_state0)
   );

   crc_frame_seq #(.CRC_W(8), .DATA_REF(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready1), .crc_rst(crc_rst1), .crc_bit(crc_bit1), .crc_en(crc_en1),
      .crc_val(crc_val1), .out_valid(out_valid1), .out_crc(out_crc1), .out_ready(out_ready),
      .busy(busy1), .dbg_state(dbg_state1)
   );

   // Engine 0: POLY=07 INIT=00 no output reflection; engine 1: POLY=31 INIT=00 reflected output.
   logic [7:0] eng0, eng1;
   always @(posedge clk) begin
      if (crc_rst0) eng0 <= 8'h00;
      else if (crc_en0) eng0 <= {eng0[6:0], 1'b0} ^ ((eng0[7] ^ crc_bit0) ? 8'h07 : 8'h00);
      if (crc_rst1) eng1 <= 8'h00;
      else if (crc_en1) eng1 <= {eng1[6:0], 1'b0} ^ ((eng1[7] ^ crc_bit1) ? 8'h31 : 8'h00);
   end

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   assign crc_val0 = eng0;
   assign crc_val1 = rev8(eng1);

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int en_cnt1 = 0;
   int wait_en_viol = 0;
   int clr_cnt0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (crc_en1 === 1'b1) en_cnt1 = en_cnt1 + 1;
      if (crc_en0 === 1'b1 && dbg_state0 == ST_WAIT) wait_en_viol = wait_en_viol + 1;
      if (dbg_state0 == ST_CLEAR) clr_cnt0 = clr_cnt0 + 1;
   end

   logic [7:0] msg [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Holds the byte until the selected instance accepts it; returns the accept cycle.
   task automatic send_byte(input int sel, input logic [7:0] d, input logic last,
                            output int acc_cyc);
      bit ok;
      ok      = 1'b0;
      in_data = d;
      in_last = last;
      if (sel != 0) in_valid1 = 1'b1;
      else          in_valid0 = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if ((sel != 0) ? in_ready1 : in_ready0) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      acc_cyc   = cyc;
      in_data   = 8'($urandom);
      in_last   = 1'($urandom);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: byte %h not accepted by dut%0d, ready=0 required 1", d, sel);
      end
   endtask

   task automatic send_frame(input int sel, input int max_bubble, output int last_acc);
      int acc;
      for (int i = 0; i < 9; i++) begin
         send_byte(sel, msg[i], (i == 8), acc);
         if (i < 8 && max_bubble > 0) repeat ($urandom_range(0, max_bubble)) @(posedge clk);
      end
      last_acc = acc;
   endtask

   // Waits for out_valid, checks latency from the last accept and the CRC value.
   task automatic wait_out(input int sel, input logic [7:0] exp_crc, input int acc_cyc,
                           input string name);
      bit seen;
      int lat;
      logic [7:0] got;
      seen = 1'b0;
      lat  = 0;
      got  = 8'h00;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         if ((sel != 0) ? out_valid1 : out_valid0) begin
            seen = 1'b1;
            lat  = cyc - acc_cyc;
            got  = (sel != 0) ? out_crc1 : out_crc0;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_out_timeout: out_valid never rose on dut%0d", name, sel);
      end else begin
         checks++;
         if (lat !== 9) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges required 9", name, lat);
         end
         checks++;
         if (got !== exp_crc) begin
            errors++;
            $display("FAIL %s_crc: got %h required %h", name, got, exp_crc);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid0 = 1'b0; in_valid1 = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready0); end
      checks++; if (crc_rst0 !== 1'b1) begin errors++; $display("FAIL rst_crc_rst: got %b required 1", crc_rst0); end
      checks++; if (crc_en0 !== 1'b0) begin errors++; $display("FAIL rst_crc_en: got %b required 0", crc_en0); end
      checks++; if (crc_bit0 !== 1'b0) begin errors++; $display("FAIL rst_crc_bit: got %b required 0", crc_bit0); end
      checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid0); end
      checks++; if (out_crc0 !== 8'h00) begin errors++; $display("FAIL rst_out_crc: got %h required 00", out_crc0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy0); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy1: got %b required 0", busy1); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dbg_state0 !== ST_IDLE) begin errors++; $display("FAIL idle_state: got %0d required 0", dbg_state0); end
      checks++; if (crc_rst0 !== 1'b1) begin errors++; $display("FAIL idle_crc_rst: got %b required 1", crc_rst0); end
   endtask

   task automatic test_msb_first();
      int acc;
      send_frame(0, 0, acc);
      wait_out(0, 8'hF4, acc, "msb");
   endtask

   task automatic test_lsb_first();
      int acc, en_start;
      en_start = en_cnt1;
      send_frame(1, 0, acc);
      wait_out(1, 8'hA1, acc, "lsb");
      checks++;
      if (en_cnt1 - en_start !== 72) begin
         errors++;
         $display("FAIL lsb_en_cycles: got %0d required 72", en_cnt1 - en_start);
      end
   endtask

   task automatic test_bubbles();
      int acc, viol_start;
      viol_start = wait_en_viol;
      send_frame(0, 5, acc);
      wait_out(0, 8'hF4, acc, "bubble");
      checks++;
      if (wait_en_viol - viol_start !== 0) begin
         errors++;
         $display("FAIL bubble_en_in_wait: got %0d cycles required 0", wait_en_viol - viol_start);
      end
   endtask

   task automatic test_hold();
      int acc;
      out_ready = 1'b0;
      send_frame(0, 0, acc);
      wait_out(0, 8'hF4, acc, "hold");
      in_valid0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid0); end
         checks++; if (out_crc0 !== 8'hF4) begin errors++; $display("FAIL hold_crc[%0d]: got %h required f4", i, out_crc0); end
         checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready0); end
      end
      in_valid0 = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b required 0", out_valid0); end
      checks++; if (dbg_state0 !== ST_IDLE) begin errors++; $display("FAIL hold_release_state: got %0d required 0", dbg_state0); end
   endtask

   task automatic test_back_to_back();
      int acc, clr_start;
      send_frame(0, 0, acc);
      wait_out(0, 8'hF4, acc, "b2b_first");
      clr_start = clr_cnt0;
      send_byte(0, 8'h31, 1'b1, acc);
      wait_out(0, 8'h97, acc, "b2b_second");
      checks++;
      if (clr_cnt0 - clr_start !== 1) begin
         errors++;
         $display("FAIL b2b_clear_pulse: got %0d cycles required 1", clr_cnt0 - clr_start);
      end
   endtask

   task automatic test_reset_mid();
      int acc, spurious;
      for (int i = 0; i < 4; i++) send_byte(0, msg[i], 1'b0, acc);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy0); end
      checks++; if (crc_rst0 !== 1'b1) begin errors++; $display("FAIL midrst_crc_rst: got %b required 1", crc_rst0); end
      checks++; if (crc_en0 !== 1'b0) begin errors++; $display("FAIL midrst_crc_en: got %b required 0", crc_en0); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid0 !== 1'b0) spurious++;
      end
      checks++; if (spurious !== 0) begin errors++; $display("FAIL midrst_spurious: got %0d cycles required 0", spurious); end
      @(posedge clk);
      #1;
      send_frame(0, 0, acc);
      wait_out(0, 8'hF4, acc, "after_rst");
      // A result held in DONE must vanish the moment reset asserts, not at the next edge.
      out_ready = 1'b0;
      send_frame(0, 0, acc);
      wait_out(0, 8'hF4, acc, "done_rst");
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL donerst_valid: got %b required 0", out_valid0); end
      checks++; if (out_crc0 !== 8'h00) begin errors++; $display("FAIL donerst_crc: got %h required 00", out_crc0); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_bubbles();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_frame_seq.md
Name: crc_frame_seq

Overview:
- Byte-stream front end for the bit-serial parameterizable CRC engine.
- Accepts framed bytes over a valid/ready handshake and serializes each byte MSb-first or LSb-first into the engine's data/enable inputs.
- Clears the engine at every frame start, then captures the engine's CRC after the last bit and presents it on a held valid/ready result port.
- Sits between a packet source (UART/SPI framer) and one crc instance; the instance is external and wired port-to-port.

Parameters:
- CRC_W, 8, width of crc_val and out_crc.
- DATA_REF, 0, 0 = shift each byte MSb first (un-reflected CRCs); 1 = LSb first (reflected CRCs).

Ports:
- clk  in  1  free-running clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data/in_last valid.
- in_data  in  8  frame byte.
- in_last  in  1  byte is the final byte of the frame.
- in_ready  out  1  sequencer accepts a byte this cycle.
- crc_rst  out  1  active-high synchronous reset to the CRC engine.
- crc_bit  out  1  serial data to the engine.
- crc_en  out  1  engine advance enable.
- crc_val  in  CRC_W  engine crc_out.
- out_valid  out  1  out_crc holds a finished frame CRC.
- out_crc  out  CRC_W  captured CRC.
- out_ready  in  1  consumer takes out_crc.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=0, crc_rst=1, crc_en=0, crc_bit=0, out_valid=0, out_crc=0, busy=0.
  - All outputs are registered or decoded from registered state.
- FSM states: IDLE, CLEAR, WAIT, SHIFT, LATCH, DONE.
- IDLE:
  - crc_rst=1, in_ready=0.
  - in_valid=1 -> CLEAR. The byte is not consumed yet.
- CLEAR: exactly 1 cycle.
  - crc_rst=1, crc_en=0.
  - -> WAIT.
- WAIT:
  - crc_rst=0, in_ready=1.
  - On in_valid&in_ready: load in_data into an 8-bit shift reg, latch in_last into last_q, clear bit counter, go to SHIFT.
  - in_valid low: stay in WAIT indefinitely; bubbles mid-frame are legal.
- SHIFT: exactly 8 cycles.
  - crc_en=1.
  - crc_bit = shreg[7] if DATA_REF=0, else shreg[0].
  - Shift reg moves one place per cycle; 3-bit counter increments.
  - On counter==7: go to LATCH if last_q, else WAIT.
  - in_ready=0 throughout, so the minimum is 9 cycles per byte.
- LATCH: 1 cycle.
  - crc_en=0; crc_val is now final after the 8th enabled edge.
  - out_crc <= crc_val; -> DONE.
- DONE:
  - out_valid=1; out_crc stable.
  - On out_valid&out_ready: out_valid falls at that edge; -> IDLE.
  - in_ready=0 while in DONE, so the next frame waits for the result to drain.
- Latency: 9 clk edges from the edge accepting the last byte to out_valid high.
  - 8 SHIFT edges plus the LATCH edge; out_valid is visible after the 9th.
- Simultaneous events:
  - in_valid in DONE is ignored until IDLE, and from IDLE it goes through CLEAR.
  - Frame start is therefore 2 cycles after out handshake at the earliest.
- Engine state between frames is don't-care; CLEAR guarantees the INIT value before every frame's first bit.
- Reset mid-frame:
  - All state is discarded, out_valid drops immediately (async), crc_rst asserts.
  - The partial frame is lost; the next accepted byte starts a new frame.
- in_last on a single-byte frame is legal (1-byte CRC).
- Zero-byte frames are not representable.
- in_data/in_last are sampled only at the accept edge; later changes have no effect.

Test Plan:
- Frame "123456789" (9 bytes, in_last on '9'), DATA_REF=0, engine POLY=07 INIT=00 REF_OUT=0 -> out_crc=F4, out_valid exactly 9 edges after the '9' accept.
- Same frame, DATA_REF=1, engine POLY=31 INIT=00 (reflected) -> out_crc=A1; crc_en high exactly 72 cycles total in the frame.
- Same as the first test with random 0-5 cycle in_valid bubbles between bytes -> out_crc still F4; crc_en never high while in WAIT.
- out_ready held low 6 cycles after out_valid -> out_valid and out_crc=F4 held stable; in_ready=0 meanwhile; the handshake returns the FSM to IDLE.
- Two back-to-back frames "123456789" then single byte 0x31 ('1'), DATA_REF=0, POLY=07 -> first F4, then 97 (independent result; CLEAR pulse seen between frames).
- rst_n pulsed low during byte 4 of a frame, then a full "123456789" frame -> out_valid drops asynchronously, no spurious result, second frame yields F4.
